gate_response_checker: RTL and testbench

//  Closes the loop on an N-input combinational gate under test.

---
 rtl/gate_chk_pkg.sv | 21 ++
 rtl/gate_chk_ref_model.sv | 32 +++
 rtl/gate_response_checker.sv | 152 +++++++++++++++
 tb/tb_gate_response_checker.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/gate_chk_pkg.sv
// gate_chk_pkg
//   Shared definitions for the gate response checker.
//   - state_t : sweep FSM state encoding (IDLE / SETTLE / SAMPLE / DONE)
//   - FUNC_*  : reference function selectors used by the FUNC parameter
//   No ports (package).

package gate_chk_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam int FUNC_AND  = 0;
  localparam int FUNC_OR   = 1;
  localparam int FUNC_XOR  = 2;
  localparam int FUNC_NAND = 3;

endpackage : gate_chk_pkg

// File: rtl/gate_chk_ref_model.sv
// gate_chk_ref_model
//   Combinational golden model of the gate under test. It turns the current
//   stimulus vector into the bit the gate is expected to produce.
// Parameters
//   N_IN  : number of gate inputs
//   FUNC  : FUNC_AND / FUNC_OR / FUNC_XOR / FUNC_NAND
// Ports
//   stim      in   N_IN   vector currently driven to the gate
//   expected  out  1      reference output for stim

module gate_chk_ref_model
  import gate_chk_pkg::*;
#(
  parameter int N_IN = 3,
  parameter int FUNC = FUNC_AND
) (
  input  logic [N_IN-1:0] stim,
  output logic            expected
);

  always_comb begin
    expected = 1'b0;
    case (FUNC)
      FUNC_AND:  expected = &stim;
      FUNC_OR:   expected = |stim;
      FUNC_XOR:  expected = ^stim;
      FUNC_NAND: expected = ~(&stim);
      default:   expected = 1'b0;
    endcase
  end

endmodule : gate_chk_ref_model

// File: rtl/gate_response_checker.sv
// gate_response_checker
//   On-chip self-test for an N_IN-input combinational gate. Sweeps every
//   input vector on stim, waits SETTLE cycles per vector, samples resp and
//   compares it with the built-in reference. Counts mismatches, captures the
//   first failing vector and reports done/pass.
// Configuration macro
//   GATE_CHK_STOP_ON_FAIL_EN : when defined, the first mismatch ends the
//                              sweep at that sample; otherwise every vector
//                              is checked and every mismatch counted.
// Parameters
//   N_IN (1..8), SETTLE (>=1), FUNC (0=AND 1=OR 2=XOR 3=NAND)
// Ports
//   clk             in   1       rising-edge clock
//   rst_n           in   1       asynchronous active-low reset
//   start           in   1       level-sampled sweep request (IDLE or DONE)
//   stim            out  N_IN    registered vector driven to the gate
//   resp            in   1       gate output
//   busy            out  1       sweep in progress
//   done            out  1       sweep finished, held until restart/reset
//   pass            out  1       done with zero mismatches
//   err_count       out  N_IN+1  mismatch count (saturates naturally at 2^N_IN)
//   fail_valid      out  1       first_fail_vec holds a captured vector
//   first_fail_vec  out  N_IN    stim value of the first mismatch

module gate_response_checker
  import gate_chk_pkg::*;
#(
  parameter int N_IN   = 3,
  parameter int SETTLE = 2,
  parameter int FUNC   = FUNC_AND
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  output logic [N_IN-1:0] stim,
  input  logic            resp,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_count,
  output logic            fail_valid,
  output logic [N_IN-1:0] first_fail_vec
);

  // The counter only has to hold SETTLE-1, but keep it at least one bit wide.
  localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(SETTLE - 1);
  localparam logic [N_IN:0]    ERR_ONE    = (N_IN+1)'(1);
  localparam logic [N_IN-1:0]  STIM_ONE   = N_IN'(1);

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  logic             expected;
  logic             mismatch;
  logic             last_vec;
  logic             stop_now;
  logic             sweep_start;

  gate_chk_ref_model #(
    .N_IN (N_IN),
    .FUNC (FUNC)
  ) u_ref (
    .stim     (stim),
    .expected (expected)
  );

  // Sample-time decisions. stop_now is the early-exit hook; with the feature
  // off it is tied low so the sweep always covers every vector.
  always_comb begin
    mismatch    = (state == ST_SAMPLE) && (resp != expected);
    last_vec    = (stim == {N_IN{1'b1}});
    sweep_start = start && ((state == ST_IDLE) || (state == ST_DONE));
`ifdef GATE_CHK_STOP_ON_FAIL_EN
    stop_now    = mismatch;
`else
    stop_now    = 1'b0;
`endif
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic. start is only honoured in IDLE and DONE, so a start
  // pulse during a sweep has no effect.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:   if (start) state_next = ST_SETTLE;
      ST_SETTLE: if (cnt == '0) state_next = ST_SAMPLE;
      ST_SAMPLE: state_next = (last_vec || stop_now) ? ST_DONE : ST_SETTLE;
      ST_DONE:   if (start) state_next = ST_SETTLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  // Status outputs decoded from state. err_count is already final when DONE
  // is entered, so pass can be derived directly.
  always_comb begin
    busy = (state == ST_SETTLE) || (state == ST_SAMPLE);
    done = (state == ST_DONE);
    pass = (state == ST_DONE) && (err_count == '0);
  end

  // Datapath: stimulus register, settle counter and result registers.
  // stim holds its last value in DONE so the final vector stays visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stim           <= '0;
      cnt            <= '0;
      err_count      <= '0;
      fail_valid     <= 1'b0;
      first_fail_vec <= '0;
    end else if (sweep_start) begin
      stim           <= '0;
      cnt            <= CNT_RELOAD;
      err_count      <= '0;
      fail_valid     <= 1'b0;
      first_fail_vec <= '0;
    end else begin
      case (state)
        ST_SETTLE: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        ST_SAMPLE: begin
          if (mismatch) begin
            err_count <= err_count + ERR_ONE;
            if (!fail_valid) begin
              first_fail_vec <= stim;
              fail_valid     <= 1'b1;
            end
          end
          if (!last_vec && !stop_now) begin
            stim <= stim + STIM_ONE;
            cnt  <= CNT_RELOAD;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule : gate_response_checker

// File: tb/tb_gate_response_checker.sv
// tb_gate_response_checker
//   Directed bench for gate_response_checker (N_IN=3, SETTLE=2, FUNC=AND).
//   A behavioural gate drives resp from stim: a correct AND, stuck-at-0 or
//   stuck-at-1. Expected values are hand-computed for those gates.
//   Build with GATE_CHK_STOP_ON_FAIL_EN defined to check the early-exit mode.

module tb_gate_response_checker;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [2:0] stim;
  logic       resp;
  logic       busy;
  logic       done;
  logic       pass;
  logic [3:0] err_count;
  logic       fail_valid;
  logic [2:0] first_fail_vec;

  // 0 = correct AND gate, 1 = stuck-at-0, 2 = stuck-at-1
  int gate_mode;
  int checks;
  int errors;
  int n;

  gate_response_checker #(
    .N_IN   (3),
    .SETTLE (2),
    .FUNC   (0)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .stim           (stim),
    .resp           (resp),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .err_count      (err_count),
    .fail_valid     (fail_valid),
    .first_fail_vec (first_fail_vec)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Gate under test model.
  always_comb begin
    case (gate_mode)
      1:       resp = 1'b0;
      2:       resp = 1'b1;
      default: resp = &stim;
    endcase
  end

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Raises start for one sampling edge and checks the sweep has begun.
  task automatic apply_stimulus(input string tag);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check_output({tag, "_busy"}, busy, 1);
    check_output({tag, "_done_low"}, done, 0);
  endtask

  // Counts edges after the start edge until done; -1 on timeout.
  task automatic wait_done(input int max_cycles, output int cycles);
    cycles = 0;
    while (cycles < max_cycles) begin
      @(posedge clk);
      cycles++;
      #1;
      if (done) break;
    end
    if (!done) cycles = -1;
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    gate_mode = 0;
    rst_n     = 1'b0;
    start     = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state
    check_output("rst_stim", stim, 0);
    check_output("rst_busy", busy, 0);
    check_output("rst_done", done, 0);
    check_output("rst_pass", pass, 0);
    check_output("rst_err", err_count, 0);
    check_output("rst_fail_valid", fail_valid, 0);
    check_output("rst_ffv", first_fail_vec, 0);
    rst_n = 1'b1;

    // Test 1: asynchronous reset mid-sweep at stim=4
    apply_stimulus("t1");
    n = 0;
    while (n < 40 && stim != 3'd4) begin
      @(posedge clk);
      n++;
      #1;
    end
    check_output("t1_reached_stim4", stim, 4);
    #2;
    rst_n = 1'b0;
    #1;
    check_output("t1_async_stim", stim, 0);
    check_output("t1_async_busy", busy, 0);
    check_output("t1_async_done", done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    apply_stimulus("t1_restart");
    wait_done(40, n);
    check_output("t1_latency", n, 24);
    check_output("t1_pass", pass, 1);

    // Test 2: correct AND gate
    $display("[TB] correct gate sweep");
    apply_stimulus("t2");
    wait_done(40, n);
    check_output("t2_latency", n, 24);
    check_output("t2_pass", pass, 1);
    check_output("t2_err", err_count, 0);
    check_output("t2_fail_valid", fail_valid, 0);
    check_output("t2_busy_low", busy, 0);
    check_output("t2_stim_held", stim, 7);

    // Test 3: stuck-at-0 (only 3'b111 mismatches)
    gate_mode = 1;
    apply_stimulus("t3");
    wait_done(40, n);
    check_output("t3_latency", n, 24);
    check_output("t3_err", err_count, 1);
    check_output("t3_fail_valid", fail_valid, 1);
    check_output("t3_ffv", first_fail_vec, 7);
    check_output("t3_pass", pass, 0);

    // Test 4: stuck-at-1 (vectors 0..6 mismatch)
    gate_mode = 2;
    apply_stimulus("t4");
    wait_done(40, n);
`ifdef GATE_CHK_STOP_ON_FAIL_EN
    check_output("t4_latency", n, 3);
    check_output("t4_err", err_count, 1);
`else
    check_output("t4_latency", n, 24);
    check_output("t4_err", err_count, 7);
`endif
    check_output("t4_ffv", first_fail_vec, 0);
    check_output("t4_fail_valid", fail_valid, 1);
    check_output("t4_pass", pass, 0);

    // Test 5: start during sweep ignored; start held in DONE restarts
    gate_mode = 1;
    apply_stimulus("t5");
    n = 0;
    while (n < 40) begin
      @(posedge clk);
      n++;
      #1;
      if (n == 5) start = 1'b1;
      if (n == 6) start = 1'b0;
      if (done) break;
    end
    check_output("t5_latency", n, 24);
    check_output("t5_err_before", err_count, 1);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    gate_mode = 0;
    check_output("t5_restart_busy", busy, 1);
    check_output("t5_restart_done", done, 0);
    check_output("t5_restart_err", err_count, 0);
    check_output("t5_restart_fail_valid", fail_valid, 0);
    check_output("t5_restart_stim", stim, 0);
    wait_done(40, n);
    check_output("t5_restart_latency", n, 24);
    check_output("t5_restart_pass", pass, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_gate_response_checker
